// File: rtl/uart_tx_cfg_if.sv
// Send handshake and serial line of the configurable UART transmitter.
//   data     payload, sampled when send_en is accepted
//   send_en  send request, accepted only while ready = 1
//   ready    transmitter is idle (or in the final stop clock) and takes send_en
//   tx_done  one-cycle pulse on the last clock of each frame
//   uart_tx  serial line, idle high, LSB first
// master = user logic driving requests, slave = the transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              send_en;
  logic              ready;
  logic              tx_done;
  logic              uart_tx;

  modport master (output data, send_en, input ready, tx_done, uart_tx);
  modport slave  (input data, send_en, output ready, tx_done, uart_tx);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits, optional odd/even parity,
// one or two stop bits, each bit BIT_CYC = CLK_FRE/BAUD clocks long.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        uart_tx_cfg_if slave: data/send_en in, ready/tx_done/uart_tx out
// A send_en in the last clock of the final stop bit starts the next frame on
// the following edge, so back-to-back frames have no idle gap.
module uart_tx_cfg #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  uart_tx_cfg_if.slave bus
);
  localparam int BIT_CYC = CLK_FRE / BAUD;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(BIT_CYC - 2);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (DATA_W < 5 || DATA_W > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY < 0 || PARITY > 2 || BIT_CYC < 2) begin : g_bad_param
      $error("uart_tx_cfg: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        idx_q;
  logic              ready_q;
  logic              done_q;
  logic              tx_q;
  logic [DATA_W-1:0] shreg_q;
  logic              par_q;

  logic bit_end;
  logic accept;
  logic shift;

  function automatic logic parity_bit(input logic [DATA_W-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  assign bit_end = (cnt_q == CNT_LAST);
  // ready_q is only high in IDLE or in the last clock of the final stop bit,
  // so it alone qualifies the request.
  assign accept  = bus.send_en && ready_q;
  // Bit 0 of the shifter is consumed when START or each DATA bit ends.
  assign shift   = bit_end && (state_q == S_START || state_q == S_DATA);

  assign bus.ready   = ready_q;
  assign bus.tx_done = done_q;
  assign bus.uart_tx = tx_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      // Wrapping at bit_end also clears the counter when START is entered
      // straight from the final stop bit.
      cnt_q  <= (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            tx_q    <= shreg_q[0];
            idx_q   <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (idx_q == DATA_LAST) begin
              idx_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= shreg_q[0];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
            idx_q   <= '0;
          end
        end
        S_STOP: begin
          // Raise done/ready one edge early so both are high during the
          // final clock of the last stop bit.
          if (idx_q == STOP_LAST && cnt_q == CNT_PRE) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
          if (bit_end) begin
            if (idx_q == STOP_LAST) begin
              idx_q <= '0;
              if (accept) begin
                state_q <= S_START;
                tx_q    <= 1'b0;
                ready_q <= 1'b0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Payload latch and parity: loaded on accept only, so requests while busy
  // cannot disturb the frame in flight.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      shreg_q <= bus.data;
      par_q   <= parity_bit(bus.data);
    end else if (shift) begin
      shreg_q <= shreg_q >> 1;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   sel = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic line, rdy, done;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_W(8)) i0 ();
  uart_tx_cfg_if #(.DATA_W(7)) i1 ();
  uart_tx_cfg_if #(.DATA_W(8)) i2 ();

  uart_tx_cfg #(.CLK_FRE(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(0), .STOP_BITS(1))
    u0 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(i0.slave));
  uart_tx_cfg #(.CLK_FRE(1_000_000), .BAUD(100_000), .DATA_W(7), .PARITY(2), .STOP_BITS(2))
    u1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(i1.slave));
  uart_tx_cfg #(.CLK_FRE(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(1), .STOP_BITS(1))
    u2 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(i2.slave));

  always_comb begin
    case (sel)
      0:       begin line = i0.uart_tx; rdy = i0.ready; done = i0.tx_done; end
      1:       begin line = i1.uart_tx; rdy = i1.ready; done = i1.tx_done; end
      default: begin line = i2.uart_tx; rdy = i2.ready; done = i2.tx_done; end
    endcase
  end

  // Reference line value for bit i of a frame (0 = start bit).
  function automatic logic frame_bit(input logic [8:0] d, input int dw, input int par, input int i);
    logic p;
    p = 1'b0;
    if (i == 0) return 1'b0;
    if (i <= dw) return d[i-1];
    if (par != 0 && i == dw + 1) begin
      for (int j = 0; j < dw; j++) p = p ^ d[j];
      return (par == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      n_cmp++; if ({i0.uart_tx, i0.ready, i0.tx_done} !== 3'b110) begin n_bad++;
        $display("FAIL reset_u0 phase=%0d got %b want 110", r, {i0.uart_tx, i0.ready, i0.tx_done}); end
      n_cmp++; if ({i1.uart_tx, i1.ready, i1.tx_done} !== 3'b110) begin n_bad++;
        $display("FAIL reset_u1 phase=%0d got %b want 110", r, {i1.uart_tx, i1.ready, i1.tx_done}); end
      n_cmp++; if ({i2.uart_tx, i2.ready, i2.tx_done} !== 3'b110) begin n_bad++;
        $display("FAIL reset_u2 phase=%0d got %b want 110", r, {i2.uart_tx, i2.ready, i2.tx_done}); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_8n1();
    logic et;
    sel = 0;
    @(negedge clk); i0.data = 8'hA5; i0.send_en = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      et = (k <= 100) ? frame_bit(9'h0A5, 8, 0, (k-1)/10) : 1'b1;
      n_cmp++; if (line !== et) begin n_bad++; $display("FAIL 8n1_tx k=%0d got %b want %b", k, line, et); end
      n_cmp++; if (rdy !== (k >= 100)) begin n_bad++; $display("FAIL 8n1_ready k=%0d got %b want %b", k, rdy, k >= 100); end
      n_cmp++; if (done !== (k == 100)) begin n_bad++; $display("FAIL 8n1_done k=%0d got %b want %b", k, done, k == 100); end
      if (k == 1) i0.send_en = 1'b0;
    end
  endtask

  task automatic test_7e2();
    logic et;
    sel = 1;
    @(negedge clk); i1.data = 7'h41; i1.send_en = 1'b1;
    for (int k = 1; k <= 115; k++) begin
      @(negedge clk);
      et = (k <= 110) ? frame_bit(9'h041, 7, 2, (k-1)/10) : 1'b1;
      n_cmp++; if (line !== et) begin n_bad++; $display("FAIL 7e2_tx k=%0d got %b want %b", k, line, et); end
      n_cmp++; if (rdy !== (k >= 110)) begin n_bad++; $display("FAIL 7e2_ready k=%0d got %b want %b", k, rdy, k >= 110); end
      n_cmp++; if (done !== (k == 110)) begin n_bad++; $display("FAIL 7e2_done k=%0d got %b want %b", k, done, k == 110); end
      if (k == 1) i1.send_en = 1'b0;
    end
  endtask

  task automatic test_odd_parity();
    logic [7:0] vec [3];
    logic et;
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h01;
    sel = 2;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk); i2.data = vec[v]; i2.send_en = 1'b1;
      for (int k = 1; k <= 115; k++) begin
        @(negedge clk);
        et = (k <= 110) ? frame_bit({1'b0, vec[v]}, 8, 1, (k-1)/10) : 1'b1;
        n_cmp++; if (line !== et) begin n_bad++; $display("FAIL odd_tx d=%h k=%0d got %b want %b", vec[v], k, line, et); end
        n_cmp++; if (done !== (k == 110)) begin n_bad++; $display("FAIL odd_done d=%h k=%0d got %b want %b", vec[v], k, done, k == 110); end
        if (k == 1) i2.send_en = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fb;
    logic et, er, ed;
    int f;
    sel = 0;
    @(negedge clk); i0.data = 8'h5A; i0.send_en = 1'b1;
    for (int k = 1; k <= 310; k++) begin
      @(negedge clk);
      f  = (k - 1) / 100;
      fb = (f == 0) ? 8'h5A : (f == 1) ? 8'h3C : 8'hC3;
      et = (f < 3) ? frame_bit({1'b0, fb}, 8, 0, ((k-1) % 100) / 10) : 1'b1;
      er = (k > 300) || (k % 100 == 0);
      ed = (k == 100) || (k == 200) || (k == 300);
      n_cmp++; if (line !== et) begin n_bad++; $display("FAIL b2b_tx k=%0d got %b want %b", k, line, et); end
      n_cmp++; if (rdy !== er) begin n_bad++; $display("FAIL b2b_ready k=%0d got %b want %b", k, rdy, er); end
      n_cmp++; if (done !== ed) begin n_bad++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, ed); end
      if (k == 50)  i0.data = 8'h3C;
      if (k == 150) i0.data = 8'hC3;
      if (k == 201) i0.send_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic et;
    sel = 0;
    @(negedge clk); i0.data = 8'hA5; i0.send_en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) i0.send_en = 1'b0;
    end
    n_cmp++; if (line !== 1'b0) begin n_bad++; $display("FAIL rst_pre_line got %b want 0", line); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({line, rdy, done} !== 3'b110) begin n_bad++; $display("FAIL rst_async got %b want 110", {line, rdy, done}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_cmp++; if ({line, rdy, done} !== 3'b110) begin n_bad++; $display("FAIL rst_idle k=%0d got %b want 110", k, {line, rdy, done}); end
    end
    @(negedge clk); i0.data = 8'h3C; i0.send_en = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      et = (k <= 100) ? frame_bit(9'h03C, 8, 0, (k-1)/10) : 1'b1;
      n_cmp++; if (line !== et) begin n_bad++; $display("FAIL rst_frame_tx k=%0d got %b want %b", k, line, et); end
      n_cmp++; if (done !== (k == 100)) begin n_bad++; $display("FAIL rst_frame_done k=%0d got %b want %b", k, done, k == 100); end
      if (k == 1) i0.send_en = 1'b0;
    end
  endtask

  task automatic test_busy_ignore();
    logic et;
    int ndone;
    ndone = 0;
    sel = 0;
    @(negedge clk); i0.data = 8'h96; i0.send_en = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      et = (k <= 100) ? frame_bit(9'h096, 8, 0, (k-1)/10) : 1'b1;
      n_cmp++; if (line !== et) begin n_bad++; $display("FAIL busy_tx k=%0d got %b want %b", k, line, et); end
      n_cmp++; if (rdy !== (k >= 100)) begin n_bad++; $display("FAIL busy_ready k=%0d got %b want %b", k, rdy, k >= 100); end
      if (done === 1'b1) ndone++;
      if (k == 1)  i0.send_en = 1'b0;
      if (k == 30) begin i0.data = 8'hFF; i0.send_en = 1'b1; end
      if (k == 31) i0.send_en = 1'b0;
    end
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL busy_done_count got %0d want 1", ndone); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    i0.data = '0; i0.send_en = 1'b0;
    i1.data = '0; i1.send_en = 1'b0;
    i2.data = '0; i2.send_en = 1'b0;
    test_reset();
    test_8n1();
    test_7e2();
    test_odd_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_busy_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
